// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: runtime-programmable clock-enable scheduler.
// Produces a registered divided clock level (clock_out) and a one-cycle
// tick on the last cycle of every period. Runs either free-running or
// for a fixed burst of periods. A stop request always finishes the
// current period first, so no truncated phase is ever emitted.
// Optional build macro CLKDIV_FREEZE_EN adds a freeze input that pauses
// counting while a run is active.
module clock_divider_ctrl #(
  parameter int DIV_W        = 28,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = 38,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_divisor,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_ticks,
  input  logic             start,
  input  logic             stop,
`ifdef CLKDIV_FREEZE_EN
  input  logic             freeze,
`endif
  output logic             clock_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   cnt, cnt_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [DIV_W-1:0]   high, high_n;
  logic [CNT_W-1:0]   ticks, ticks_n;
  logic [CNT_W-1:0]   tick_count_n;
  logic               clock_out_n, tick_n, done_n;

  logic [DIV_W-1:0]   cfg_div_c, cfg_high_c;
  logic               last, burst_end, frozen;
  logic [CNT_W-1:0]   tick_count_inc;

  // Config clamping: period at least 2, high phase within [1, div-1] so
  // both phases are always present.
  assign cfg_div_c  = (cfg_divisor < DIV_W'(2)) ? DIV_W'(2) : cfg_divisor;
  assign cfg_high_c = (cfg_high == '0)                   ? DIV_W'(1) :
                      (cfg_high > cfg_div_c - DIV_W'(1)) ? cfg_div_c - DIV_W'(1) :
                                                           cfg_high;

  assign last           = (cnt == div - DIV_W'(1));
  assign tick_count_inc = (tick_count == '1) ? tick_count : tick_count + CNT_W'(1);
  // Widened compare so ticks == all-ones still terminates correctly.
  assign burst_end      = (ticks != '0) &&
                          (({1'b0, tick_count} + (CNT_W+1)'(1)) == {1'b0, ticks});

`ifdef CLKDIV_FREEZE_EN
  assign frozen = freeze;
`else
  assign frozen = 1'b0;
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-output logic; every registered value is computed here.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    div_n        = div;
    high_n       = high;
    ticks_n      = ticks;
    tick_count_n = tick_count;
    clock_out_n  = 1'b0;
    tick_n       = 1'b0;
    done_n       = 1'b0;

    // Transfer only happens in IDLE; a start in the same cycle sees the new
    // values because counting begins on the following edge.
    if (cfg_valid && cfg_ready) begin
      div_n   = cfg_div_c;
      high_n  = cfg_high_c;
      ticks_n = cfg_ticks;
    end

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n      = RUN;
          tick_count_n = '0;
        end
      end
      RUN, STOPPING: begin
        if (frozen) begin
          // Hold the phase; a stop request is remembered but not acted on.
          clock_out_n = clock_out;
          if (stop && state == RUN) state_n = STOPPING;
        end else begin
          clock_out_n = (cnt < high);
          tick_n      = last;
          cnt_n       = last ? '0 : cnt + DIV_W'(1);
          if (last) begin
            tick_count_n = tick_count_inc;
            // Any of these ends the run at this period boundary; one done only.
            if (state == STOPPING || stop || burst_end) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else if (stop) begin
            state_n = STOPPING;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset (aborts any run).
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      clock_out  <= 1'b0;
      tick       <= 1'b0;
      done       <= 1'b0;
      tick_count <= '0;
      div        <= DIV_W'(DEFAULT_DIV);
      high       <= DIV_W'(DEFAULT_HIGH);
      ticks      <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      clock_out  <= clock_out_n;
      tick       <= tick_n;
      done       <= done_n;
      tick_count <= tick_count_n;
      div        <= div_n;
      high       <= high_n;
      ticks      <= ticks_n;
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl. Inputs change 1ns after the
// rising edge; outputs are sampled at the same point, so the value seen
// after step i is what edge i registered (edge 0 = start-accepting edge).
module tb_clock_divider_ctrl;
  localparam int DIV_W = 28;
  localparam int CNT_W = 16;

  logic             clock_in = 1'b0;
  logic             reset, cfg_valid, start, stop;
  logic             cfg_ready, clock_out, tick, busy, done;
  logic [DIV_W-1:0] cfg_divisor, cfg_high;
  logic [CNT_W-1:0] cfg_ticks, tick_count;
`ifdef CLKDIV_FREEZE_EN
  logic             freeze;
`endif

  int n_vec = 0;
  int n_bad = 0;

  clock_divider_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(38), .DEFAULT_HIGH(1)) dut (
    .clock_in(clock_in), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_divisor(cfg_divisor), .cfg_high(cfg_high), .cfg_ticks(cfg_ticks),
    .start(start), .stop(stop),
`ifdef CLKDIV_FREEZE_EN
    .freeze(freeze),
`endif
    .clock_out(clock_out), .tick(tick), .busy(busy), .done(done),
    .tick_count(tick_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic expect_out(input string tag, input int i, input bit c, input bit t,
                            input bit d, input bit b, input int tc);
    check($sformatf("%s[%0d].clock_out", tag, i), 32'(clock_out), 32'(c));
    check($sformatf("%s[%0d].tick", tag, i),      32'(tick), 32'(t));
    check($sformatf("%s[%0d].done", tag, i),      32'(done), 32'(d));
    check($sformatf("%s[%0d].busy", tag, i),      32'(busy), 32'(b));
    check($sformatf("%s[%0d].tick_count", tag, i), 32'(tick_count), 32'(tc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Single-cycle start with optional config transfer in the same cycle.
  task automatic kick(input bit load, input int dv, input int hi, input int tk);
    cfg_valid   = load;
    cfg_divisor = DIV_W'(dv);
    cfg_high    = DIV_W'(hi);
    cfg_ticks   = CNT_W'(tk);
    start       = 1'b1;
    step();
    cfg_valid   = 1'b0;
    start       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_divisor = '0; cfg_high = '0; cfg_ticks = '0;
`ifdef CLKDIV_FREEZE_EN
    freeze = 1'b0;
`endif
    step(); step();
    reset = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.cfg_ready", 32'(cfg_ready), 32'd1);

    // Defaults 38/1 free-run: high on cnt 0, tick on cnt 37.
    kick(0, 0, 0, 0);
    for (int i = 1; i <= 80; i++) begin
      step();
      expect_out("dflt", i, (i % 38) == 1, (i % 38) == 0, 0, 1, i / 38);
    end
    do_reset();

    // 4/2 burst of 3 with config in the start cycle: pattern 1100 x3.
    kick(1, 4, 2, 3);
    for (int i = 1; i <= 14; i++) begin
      step();
      expect_out("burst", i, (i <= 12) && (((i - 1) % 4) < 2), (i % 4) == 0 && i <= 12,
                 i == 12, i < 12, (i <= 12) ? i / 4 : 3);
    end

    // 10/5 free-run, stop seen with cnt=3: period completes, then IDLE.
    kick(1, 10, 5, 0);
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 4) stop = 1'b0;
      expect_out("stop", i, i <= 5, i == 10, i == 10, i < 10, (i >= 10) ? 1 : 0);
      if (i == 3) stop = 1'b1;
    end
    // stop in IDLE is ignored.
    stop = 1'b1; step(); stop = 1'b0; step();
    check("idle_stop.busy", 32'(busy), 32'd0);
    check("idle_stop.done", 32'(done), 32'd0);

    // Stop on the last cycle of the period: direct to IDLE with done.
    kick(1, 4, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) stop = 1'b0;
      expect_out("stoplast", i, i == 1, i == 4, i == 4, i < 4, (i >= 4) ? 1 : 0);
      if (i == 3) stop = 1'b1;
    end

    // Stop and burst end in the same period: exactly one done.
    kick(1, 4, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3) stop = 1'b0;
      expect_out("stopburst", i, i == 1, i == 4, i == 4, i < 4, (i >= 4) ? 1 : 0);
      if (i == 2) stop = 1'b1;
    end

    // Clamp 0/0 -> 2/1, burst 2; cfg and start offered while busy are held off.
    kick(1, 0, 0, 2);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) begin cfg_valid = 1'b0; start = 1'b0; end
      expect_out("clamp2", i, (i <= 4) && (i % 2 == 1), (i % 2 == 0) && i <= 4,
                 i == 4, i < 4, (i <= 4) ? i / 2 : 2);
      if (i == 2 || i == 3) check($sformatf("busycfg[%0d].cfg_ready", i), 32'(cfg_ready), 32'd0);
      if (i == 1) begin
        cfg_valid = 1'b1; cfg_divisor = 20; cfg_high = 3; cfg_ticks = 1; start = 1'b1;
      end
    end
    // Same run again without a transfer: config must still be 2/1 x2.
    kick(0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_out("keep", i, (i <= 4) && (i % 2 == 1), (i % 2 == 0) && i <= 4,
                 i == 4, i < 4, (i <= 4) ? i / 2 : 2);
    end

    // Clamp 5/9 -> high 4, burst 1.
    kick(1, 5, 9, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      expect_out("clamp5", i, i <= 4, i == 5, i == 5, i < 5, (i >= 5) ? 1 : 0);
    end

    // Reset mid-burst (8/4 x5 after 2 ticks) restores 38/1 free-run.
    kick(1, 8, 4, 5);
    for (int i = 1; i <= 17; i++) step();
    check("midrst.pre_tick_count", 32'(tick_count), 32'd2);
    do_reset();
    expect_out("midrst", 0, 0, 0, 0, 0, 0);
    kick(0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step();
      expect_out("postrst", i, (i % 38) == 1, (i % 38) == 0, 0, 1, i / 38);
    end
    do_reset();

`ifdef CLKDIV_FREEZE_EN
    // 6/3, freeze 4 cycles with cnt=2: phase holds, period stretches to 10.
    kick(1, 6, 3, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 6) freeze = 1'b0;
      expect_out("freeze", i, (i <= 7) || (i == 11) || (i == 12), i == 10, 0, 1,
                 (i >= 10) ? 1 : 0);
      if (i == 2) freeze = 1'b1;
    end
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
